// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit/receive pair.
//   uart_state_e : frame state machine encoding (used by uart_tx and uart_rx)
//   LINE_*       : serial line levels for idle, start and stop
//   SYNC_STAGES  : depth of the receive line synchronizer
//   baud_div()   : clock cycles per line bit (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  localparam int SYNC_STAGES = 2;

  function automatic int baud_div(input int clockrate, input int baud);
    return clockrate / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// N-flop synchronizer for an asynchronous single-bit input.
// Parameters:
//   N         : number of flops (>= 1)
//   RESET_VAL : value every flop takes on reset
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output, N cycles behind d_i
// -----------------------------------------------------------------------------
module uart_sync #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] stage_q;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) stage_q[gi] <= RESET_VAL;
          else       stage_q[gi] <= d_i;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset) stage_q[gi] <= RESET_VAL;
          else       stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: start / LSB-first data / [parity] / stop, sampled at mid-bit.
// Build option:
//   UART_RX_PARITY_EN defined   -> one even-parity bit follows the data
//   UART_RX_PARITY_EN undefined -> no parity bit, rx_parity_err tied to 0
// Parameters: CLOCKRATE (Hz), BAUD (bit/s), WORD_LENGTH (data bits, >= 2)
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   UART_RX        : asynchronous serial line, idle high
//   rx_data        : received word
//   rx_data_valid  : word + flags valid, held until accepted
//   rx_data_ready  : downstream accept
//   rx_parity_err  : parity mismatch on presented word
//   rx_frame_err   : stop bit was low on presented word
//   rx_overrun     : one-cycle pulse when a completed frame is dropped
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKRATE   = 100000000,
  parameter int BAUD        = 115200,
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   UART_RX,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_data_valid,
  input  logic                   rx_data_ready,
  output logic                   rx_parity_err,
  output logic                   rx_frame_err,
  output logic                   rx_overrun
);

  localparam int BIT_MAX  = baud_div(CLOCKRATE, BAUD);
  localparam int HALF_MAX = BIT_MAX / 2;
  localparam int CNT_W    = $clog2(BIT_MAX);
  localparam int BIT_W    = $clog2(WORD_LENGTH + 1);

  logic rx_s;

  uart_sync #(
    .N         (SYNC_STAGES),
    .RESET_VAL (LINE_IDLE)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (UART_RX),
    .q_o   (rx_s)
  );

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic [WORD_LENGTH-1:0] shift_q;
  logic [WORD_LENGTH-1:0] data_q;
  logic                   valid_q;
  logic                   perr_q;
  logic                   ferr_q;
  logic                   ovr_q;
  logic [1:0]             prime_q;
  logic                   armed_q;

  logic half_hit, bit_hit, last_bit;
  logic shift_en, frame_done, accept, load;

  assign half_hit = (cnt_q == CNT_W'(HALF_MAX - 1));
  assign bit_hit  = (cnt_q == CNT_W'(BIT_MAX - 1));
  assign last_bit = (bit_cnt_q == BIT_W'(WORD_LENGTH - 1));

  // The synchronizer comes out of reset showing idle regardless of the
  // real line. prime_q waits until it has been refilled from the pin; only
  // then can a genuine high level arm start detection, so a line that was
  // low through reset cannot be mistaken for a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_q <= '0;
      armed_q <= 1'b0;
    end else begin
      if (prime_q != 2'(SYNC_STAGES)) prime_q <= prime_q + 2'd1;
      if (prime_q == 2'(SYNC_STAGES) && rx_s == LINE_IDLE) armed_q <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= UART_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      UART_IDLE:
        if (armed_q && rx_s == LINE_START) state_d = UART_START;
      UART_START:
        if (half_hit) state_d = (rx_s == LINE_START) ? UART_DATA : UART_IDLE;
      UART_DATA:
`ifdef UART_RX_PARITY_EN
        if (bit_hit && last_bit) state_d = UART_PARITY;
      UART_PARITY:
        if (bit_hit) state_d = UART_STOP;
`else
        if (bit_hit && last_bit) state_d = UART_STOP;
`endif
      UART_STOP:
        if (bit_hit) state_d = UART_IDLE;
      default:
        state_d = UART_IDLE;
    endcase
  end

  // Output / control strobes
  always_comb begin
    shift_en   = (state_q == UART_DATA) && bit_hit;
    frame_done = (state_q == UART_STOP) && bit_hit;
    accept     = valid_q && rx_data_ready;
    load       = frame_done && (!valid_q || accept);
  end

  // Bit timer: restarts on each state change and at each bit boundary.
  always_ff @(posedge clk) begin
    if (reset || state_d != state_q || bit_hit) cnt_q <= '0;
    else                                        cnt_q <= cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || state_q != UART_DATA) bit_cnt_q <= '0;
    else if (shift_en)                 bit_cnt_q <= bit_cnt_q + BIT_W'(1);
  end

  // LSB arrives first, so shifting in at the MSB leaves it in bit 0.
  always_ff @(posedge clk) begin
    if (reset)         shift_q <= '0;
    else if (shift_en) shift_q <= {rx_s, shift_q[WORD_LENGTH-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  logic par_sample;
  logic par_err_q;

  assign par_sample = (state_q == UART_PARITY) && bit_hit;

  // Even parity: the received bit must equal the XOR of the data bits.
  always_ff @(posedge clk) begin
    if (reset)           par_err_q <= 1'b0;
    else if (par_sample) par_err_q <= (rx_s != ^shift_q);
  end
`else
  logic par_err_q;
  assign par_err_q = 1'b0;
`endif

  // Presentation register: a frame finishing while the previous word is
  // still held (and not accepted this cycle) is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= frame_done && !load;
      if (load) begin
        data_q  <= shift_q;
        perr_q  <= par_err_q;
        ferr_q  <= (rx_s != LINE_STOP);
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. The receiver runs with a 32-cycle bit
// period (same ratios as the default 868-cycle setting, scaled so many frames
// fit in a short run). Frames are serialized here from data/parity/stop
// values; expected words and flags are queued and checked on each handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_HZ  = 3200000;
  localparam int BAUD_HZ = 100000;
  localparam int BITP    = CLK_HZ / BAUD_HZ;   // 32 cycles per bit
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       UART_RX;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;

  uart_rx #(
    .CLOCKRATE   (CLK_HZ),
    .BAUD        (BAUD_HZ),
    .WORD_LENGTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .UART_RX       (UART_RX),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         par_bit;
    bit         stop_bit;
    int         period;
    logic [7:0] exp_data;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   ovr_seen = 0;
  int   valid_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Handshake monitor: samples between the input drive (negedge) and the
  // next active edge.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (rx_overrun) ovr_seen++;
      if (rx_data_valid) valid_cycles++;
      if (rx_data_valid && rx_data_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_frame: got data %02h, required no frame", rx_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("frame: data %02h pe %0b fe %0b (expected %02h %0b %0b)",
                   rx_data, rx_parity_err, rx_frame_err, e.d, e.pe, e.fe);
          check("rx_data", 32'(rx_data), 32'(e.d));
          check("rx_parity_err", 32'(rx_parity_err), 32'(e.pe));
          check("rx_frame_err", 32'(rx_frame_err), 32'(e.fe));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v, input int n);
    UART_RX = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par, input bit stop, input int p);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (PAR_EN) drive_bit(par, p);
    drive_bit(stop, p);
    drive_bit(1'b1, 2 * p);
  endtask

  task automatic expect_drained(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 4 * BITP) begin
      @(negedge clk);
      waited++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int vc0;
    int ovr0;
    clk = 1'b0;
    reset = 1'b1;
    UART_RX = 1'b1;
    rx_data_ready = 1'b1;

    //          data   par   stop per  exp    pe      fe
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 32, 8'hA5, 1'b0,   1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 32, 8'h3C, PAR_EN, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 32, 8'h01, 1'b0,   1'b1};
    vecs[3] = '{8'h96, 1'b0, 1'b1, 33, 8'h96, 1'b0,   1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 32, 8'h00, 1'b0,   1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 31, 8'hFF, PAR_EN, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 33, 8'h80, 1'b0,   1'b0};

    // Reset state
    repeat (5) @(negedge clk);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_valid", 32'(rx_data_valid), 32'd0);
    check("reset_perr", 32'(rx_parity_err), 32'd0);
    check("reset_ferr", 32'(rx_frame_err), 32'd0);
    check("reset_ovr", 32'(rx_overrun), 32'd0);
    reset = 1'b0;
    drive_bit(1'b1, 4 * BITP);

    // Directed table, ready held high: one valid cycle per frame
    valid_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe});
      send_frame(vecs[i].data, vecs[i].par_bit, vecs[i].stop_bit, vecs[i].period);
      expect_drained("table_drain");
    end
    check("table_valid_cycles", 32'(valid_cycles), 32'd7);

    // Short low glitch on idle line: rejected, then a normal frame works
    vc0 = valid_cycles;
    drive_bit(1'b0, 11);
    drive_bit(1'b1, 3 * BITP);
    check("glitch_valid", 32'(rx_data_valid), 32'd0);
    check("glitch_no_frame", 32'(valid_cycles), 32'(vc0));
    check("glitch_no_ovr", 32'(ovr_seen), 32'd0);
    exp_q.push_back('{8'hC3, 1'b0, 1'b0});
    send_frame(8'hC3, 1'b0, 1'b1, BITP);
    expect_drained("glitch_followup_drain");

    // Overrun: second frame dropped while the first is held
    rx_data_ready = 1'b0;
    exp_q.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b0, 1'b1, BITP);
    ovr0 = ovr_seen;
    send_frame(8'h22, 1'b0, 1'b1, BITP);
    check("ovr_valid_held", 32'(rx_data_valid), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    check("ovr_pulse_count", 32'(ovr_seen - ovr0), 32'd1);
    rx_data_ready = 1'b1;
    expect_drained("ovr_drain");
    @(negedge clk);
    check("ovr_valid_dropped", 32'(rx_data_valid), 32'd0);

    // Reset mid-frame after 4 data bits of 0xFF, then a clean 0x5A
    drive_bit(1'b0, BITP);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BITP);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    check("midreset_valid", 32'(rx_data_valid), 32'd0);
    drive_bit(1'b1, 2 * BITP);
    exp_q.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1, BITP);
    expect_drained("midreset_drain");

    // Line held low through reset must not start a frame
    vc0 = valid_cycles;
    UART_RX = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    drive_bit(1'b0, 3 * BITP);
    drive_bit(1'b1, 2 * BITP);
    check("lowreset_no_frame", 32'(valid_cycles), 32'(vc0));
    check("lowreset_valid", 32'(rx_data_valid), 32'd0);
    exp_q.push_back('{8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1, BITP);
    expect_drained("lowreset_drain");

    // Random frames at +/-3% bit period against the reference rules
    for (int n = 0; n < 10; n++) begin
      logic [7:0] d;
      bit         par;
      int         p;
      bit         pe;
      d   = 8'($urandom_range(0, 255));
      par = 1'($urandom_range(0, 1));
      p   = $urandom_range(BITP - 1, BITP + 1);
      pe  = PAR_EN && (par != (($countones(d) % 2) == 1));
      exp_q.push_back('{d, pe, 1'b0});
      send_frame(d, par, 1'b1, p);
      expect_drained("random_drain");
    end

    check("total_overruns", 32'(ovr_seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
